tagged_sram: RTL and testbench

- Word-addressed single-port memory that sits directly downstream of the AXI-to-memory adapter. It consumes the adapter's req/we/addr/be/user/data request and returns read data and user bits.
- Stores one user field per data word. User bit 0 is the CHERI capability tag.
- Enforces the tag-invalidation rule: any write that does not cover the full word clears the stored user field.
- Returns read data after a fixed, parameterised latency. The default latency of 1 matches the adapter's next-cycle data expectation.

---
 rtl/tagged_sram_pkg.sv | 12 +
 rtl/tagged_sram_if.sv | 28 ++
 rtl/tagged_sram_rsp_pipe.sv | 46 ++++
 rtl/tagged_sram.sv | 109 ++++++++++
 tb/tb_tagged_sram.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tagged_sram_pkg.sv
// rtl/tagged_sram_pkg.sv - shared constants and width helpers for the tagged word memory
package tagged_sram_pkg;

    // User bit that carries the CHERI capability tag.
    localparam int TAG_BIT = 0;

    // Number of byte-offset bits in a word address (log2 of bytes per word).
    function automatic int log2_bytes(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/tagged_sram_if.sv
// rtl/tagged_sram_if.sv - request/response bundle between the AXI-to-memory adapter and tagged_sram
// Ports: req_i/we_i/addr_i/be_i/user_i/data_i request from master; data_o/user_o/rvalid_o/err_o response from slave.
interface tagged_sram_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int USER_W = 10
);
    logic                req_i;
    logic                we_i;
    logic [ADDR_W-1:0]   addr_i;
    logic [DATA_W/8-1:0] be_i;
    logic [USER_W-1:0]   user_i;
    logic [DATA_W-1:0]   data_i;
    logic [DATA_W-1:0]   data_o;
    logic [USER_W-1:0]   user_o;
    logic                rvalid_o;
    logic                err_o;

    modport master (
        output req_i, we_i, addr_i, be_i, user_i, data_i,
        input  data_o, user_o, rvalid_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, user_i, data_i,
        output data_o, user_o, rvalid_o, err_o
    );
endinterface

// File: rtl/tagged_sram_rsp_pipe.sv
// rtl/tagged_sram_rsp_pipe.sv - valid-qualified response delay line with asynchronous flush
// Ports: clk/rst (async active-high flush), in_valid/in_data -> out_valid/out_data after STAGES cycles.
module tagged_sram_rsp_pipe #(
    parameter int STAGES = 0,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_delay
            logic [STAGES-1:0] vld;
            logic [WIDTH-1:0]  dat [STAGES];

            // Data only advances with its valid so the last stage holds the
            // most recent response while the line is idle.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= '0;
                    for (int i = 0; i < STAGES; i++) dat[i] <= '0;
                end else begin
                    vld[0] <= in_valid;
                    if (in_valid) dat[0] <= in_data;
                    for (int i = 1; i < STAGES; i++) begin
                        vld[i] <= vld[i-1];
                        if (vld[i-1]) dat[i] <= dat[i-1];
                    end
                end
            end

            assign out_valid = vld[STAGES-1];
            assign out_data  = dat[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/tagged_sram.sv
// rtl/tagged_sram.sv - single-port word memory with per-word user/tag field and tag invalidation on partial writes
// Ports: clk_i, rst_i (async active-high), bus (slave: request in, read data/user/rvalid/err out).
module tagged_sram
    import tagged_sram_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH = 64,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter int          AXI_USER_WIDTH = 10,
    parameter int          DEPTH          = 256,
    parameter logic [63:0] BASE_ADDR      = 64'h0,
    parameter int          READ_LATENCY   = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    tagged_sram_if.slave bus
);

    localparam int BYTES    = AXI_DATA_WIDTH / 8;
    localparam int OFF_BITS = log2_bytes(AXI_DATA_WIDTH);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] BASE = AXI_ADDR_WIDTH'(BASE_ADDR);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $fatal(1, "tagged_sram: READ_LATENCY must be 1..4");
        end
        if ((BASE_ADDR % BYTES) != 0) begin : g_bad_base
            $fatal(1, "tagged_sram: BASE_ADDR must be word-aligned");
        end
        if (AXI_USER_WIDTH < 1) begin : g_bad_user
            $fatal(1, "tagged_sram: AXI_USER_WIDTH must be at least 1");
        end
    endgenerate

    typedef struct packed {
        logic                      err;
        logic [AXI_USER_WIDTH-1:0] user;
        logic [AXI_DATA_WIDTH-1:0] data;
    } rsp_t;

    logic [AXI_DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [AXI_USER_WIDTH-1:0] user_mem [DEPTH];

    logic [AXI_ADDR_WIDTH-1:0] off;
    logic [AXI_ADDR_WIDTH-1:0] idx_full;
    logic [IDX_W-1:0]          idx;
    logic                      oor;
    logic                      wr;
    logic                      rd;

    // Byte offset bits are simply shifted away, so addresses are force-aligned.
    assign off      = bus.addr_i - BASE;
    assign idx_full = off >> OFF_BITS;
    assign idx      = idx_full[IDX_W-1:0];
    assign oor      = (bus.addr_i < BASE) || (idx_full >= AXI_ADDR_WIDTH'(DEPTH));
    assign wr       = bus.req_i & bus.we_i & ~oor;
    assign rd       = bus.req_i & ~bus.we_i;

    // Data array has no reset; gating on rst_i keeps requests during reset inert.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr) begin
            for (int k = 0; k < BYTES; k++) begin
                if (bus.be_i[k]) data_mem[idx][k*8 +: 8] <= bus.data_i[k*8 +: 8];
            end
        end
    end

    rsp_t s1_rsp;
    logic s1_valid;

    // User array is reset wholesale so no capability tag survives reset.
    // Any write narrower than the full word invalidates the stored user field.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_rsp   <= '0;
            for (int i = 0; i < DEPTH; i++) user_mem[i] <= '0;
        end else begin
            s1_valid <= rd;
            if (rd) begin
                s1_rsp.err  <= oor;
                s1_rsp.user <= oor ? '0 : user_mem[idx];
                s1_rsp.data <= oor ? '0 : data_mem[idx];
            end
            if (wr) user_mem[idx] <= (&bus.be_i) ? bus.user_i : '0;
        end
    end

    rsp_t out_rsp;
    logic out_valid;

    tagged_sram_rsp_pipe #(
        .STAGES (READ_LATENCY - 1),
        .WIDTH  ($bits(rsp_t))
    ) u_rsp_pipe (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (s1_valid),
        .in_data   (s1_rsp),
        .out_valid (out_valid),
        .out_data  (out_rsp)
    );

    assign bus.rvalid_o = out_valid;
    assign bus.err_o    = out_valid & out_rsp.err;
    assign bus.data_o   = out_rsp.data;
    assign bus.user_o   = out_rsp.user;

endmodule

// File: tb/tb_tagged_sram.sv
// tb/tb_tagged_sram.sv - scoreboard bench for tagged_sram at latency 1 (base 0) and latency 3 (base 0x1000)
module tb_tagged_sram;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    tagged_sram_if #(.ADDR_W(64), .DATA_W(64), .USER_W(10)) ia ();
    tagged_sram_if #(.ADDR_W(64), .DATA_W(64), .USER_W(10)) ib ();

    tagged_sram #(.READ_LATENCY(1)) u_a (.clk_i(clk), .rst_i(rst), .bus(ia));
    tagged_sram #(.BASE_ADDR(64'h1000), .READ_LATENCY(3)) u_b (.clk_i(clk), .rst_i(rst), .bus(ib));

    typedef struct {
        int          due;
        logic [63:0] data;
        logic [9:0]  user;
        logic        err;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    logic [63:0] md [2][256];
    logic [9:0]  mu [2][256];

    function automatic logic [63:0] base_of(input int s);
        return (s == 0) ? 64'h0 : 64'h1000;
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int s, input logic r, input logic w, input logic [63:0] a,
                         input logic [7:0] b, input logic [9:0] u, input logic [63:0] d);
        ia.req_i = 1'b0; ib.req_i = 1'b0;
        if (s == 0) begin
            ia.req_i = r; ia.we_i = w; ia.addr_i = a; ia.be_i = b; ia.user_i = u; ia.data_i = d;
        end else begin
            ib.req_i = r; ib.we_i = w; ib.addr_i = a; ib.be_i = b; ib.user_i = u; ib.data_i = d;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ia.req_i = 1'b0;
            ib.req_i = 1'b0;
        end
    endtask

    // One request for one cycle; updates the model or pushes the expected response.
    task automatic op(input int s, input bit we, input logic [63:0] addr, input logic [7:0] be,
                      input logic [9:0] user, input logic [63:0] data);
        logic [63:0] off, idx;
        bit oor;
        exp_t e;
        @(negedge clk);
        drive(s, 1'b1, we, addr, be, user, data);
        off = addr - base_of(s);
        idx = off >> 3;
        oor = (addr < base_of(s)) || (idx >= 64'd256);
        if (we) begin
            if (!oor) begin
                for (int k = 0; k < 8; k++)
                    if (be[k]) md[s][idx[7:0]][k*8 +: 8] = data[k*8 +: 8];
                mu[s][idx[7:0]] = (be == 8'hFF) ? user : 10'h0;
            end
        end else begin
            e.due  = cyc + lat_of(s);
            e.err  = oor;
            e.data = oor ? 64'h0 : md[s][idx[7:0]];
            e.user = oor ? 10'h0 : mu[s][idx[7:0]];
            if (s == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (qa.size() != 0 && qa[0].due == cyc) begin
                ea = qa.pop_front();
                check("a_rvalid", 64'(ia.rvalid_o), 64'd1);
                check("a_data", ia.data_o, ea.data);
                check("a_user", 64'(ia.user_o), 64'(ea.user));
                check("a_err", 64'(ia.err_o), 64'(ea.err));
            end else begin
                check("a_idle", 64'({ia.rvalid_o, ia.err_o}), 64'd0);
            end
            if (qb.size() != 0 && qb[0].due == cyc) begin
                eb = qb.pop_front();
                check("b_rvalid", 64'(ib.rvalid_o), 64'd1);
                check("b_data", ib.data_o, eb.data);
                check("b_user", 64'(ib.user_o), 64'(eb.user));
                check("b_err", 64'(ib.err_o), 64'(eb.err));
            end else begin
                check("b_idle", 64'({ib.rvalid_o, ib.err_o}), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        drive(0, 1'b0, 1'b0, 64'h0, 8'h0, 10'h0, 64'h0);
        ib.req_i = 1'b0; ib.we_i = 1'b0; ib.addr_i = '0; ib.be_i = '0; ib.user_i = '0; ib.data_i = '0;
        for (int s = 0; s < 2; s++) for (int i = 0; i < 256; i++) mu[s][i] = 10'h0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_data", ia.data_o, 64'h0);
        check("rst_a_user", 64'(ia.user_o), 64'h0);
        check("rst_a_rvalid", 64'(ia.rvalid_o), 64'h0);
        check("rst_a_err", 64'(ia.err_o), 64'h0);
        check("rst_b_data", ib.data_o, 64'h0);
        check("rst_b_user", 64'(ib.user_o), 64'h0);
        check("rst_b_rvalid", 64'(ib.rvalid_o), 64'h0);
        @(negedge clk) rst = 1'b0;

        // Full write, read-after-write, partial write clears tag.
        op(0, 1, 64'h10, 8'hFF, 10'h001, 64'hDEADBEEF_CAFEF00D);
        op(0, 0, 64'h10, 8'h00, 10'h000, 64'h0);
        op(0, 1, 64'h10, 8'h0F, 10'h3FF, 64'h11111111_22222222);
        op(0, 0, 64'h10, 8'h00, 10'h000, 64'h0);
        // be == 0 write still clears the stored user field.
        op(0, 1, 64'h20, 8'hFF, 10'h155, 64'h0123456789ABCDEF);
        op(0, 0, 64'h20, 8'h00, 10'h000, 64'h0);
        op(0, 1, 64'h20, 8'h00, 10'h2AA, 64'hFFFFFFFFFFFFFFFF);
        op(0, 0, 64'h20, 8'h00, 10'h000, 64'h0);
        // Unaligned addresses land on the containing word.
        op(0, 1, 64'h13, 8'hFF, 10'h002, 64'hA5A5A5A5_5A5A5A5A);
        op(0, 0, 64'h17, 8'h00, 10'h000, 64'h0);
        op(0, 0, 64'h10, 8'h00, 10'h000, 64'h0);
        // Last word and first out-of-range word.
        op(0, 1, 64'h7F8, 8'hFF, 10'h3C3, 64'h0F0F0F0F_F0F0F0F0);
        op(0, 1, 64'h800, 8'hFF, 10'h111, 64'h9999999999999999);
        op(0, 0, 64'h7F8, 8'h00, 10'h000, 64'h0);
        op(0, 0, 64'h800, 8'h00, 10'h000, 64'h0);
        idle(3);
        check("a_hold_data", ia.data_o, 64'h0);
        check("a_hold_user", 64'(ia.user_o), 64'h0);

        // Latency 3, base 0x1000: back-to-back reads in order, range checks.
        op(1, 1, 64'h1000, 8'hFF, 10'h00A, 64'h1000_0000_0000_0001);
        op(1, 1, 64'h1008, 8'hFF, 10'h00B, 64'h1000_0000_0000_0002);
        op(1, 1, 64'h1010, 8'hFF, 10'h00C, 64'h1000_0000_0000_0003);
        op(1, 0, 64'h1000, 8'h00, 10'h000, 64'h0);
        op(1, 0, 64'h1008, 8'h00, 10'h000, 64'h0);
        op(1, 0, 64'h1010, 8'h00, 10'h000, 64'h0);
        op(1, 1, 64'h1800, 8'hFF, 10'h3FF, 64'hBADBADBADBADBAD0);
        op(1, 1, 64'h17F8, 8'hFF, 10'h3FF, 64'h7777_8888_9999_AAAA);
        op(1, 0, 64'h1800, 8'h00, 10'h000, 64'h0);
        op(1, 0, 64'h0FF8, 8'h00, 10'h000, 64'h0);
        op(1, 0, 64'h17F8, 8'h00, 10'h000, 64'h0);
        idle(5);
        check("b_hold_user", 64'(ib.user_o), 64'h3FF);

        // Mixed random traffic on the first eight words of instance b.
        for (int w = 3; w < 8; w++)
            op(1, 1, 64'h1000 + 64'(w * 8), 8'hFF, 10'($urandom), {$urandom, $urandom});
        for (int i = 0; i < 60; i++) begin
            logic [63:0] a;
            logic [7:0] be;
            a  = 64'h1000 + 64'($urandom_range(0, 7) * 8) + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 64'h1800 + 64'($urandom_range(0, 63));
            be = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            op(1, bit'($urandom_range(0, 1)), a, be, 10'($urandom), {$urandom, $urandom});
        end
        idle(5);

        // Reset while a read is in flight; a request held during reset is ignored.
        op(1, 0, 64'h1008, 8'h00, 10'h000, 64'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        qa.delete();
        qb.delete();
        for (int s = 0; s < 2; s++) for (int i = 0; i < 256; i++) mu[s][i] = 10'h0;
        drive(0, 1'b1, 1'b1, 64'h10, 8'hFF, 10'h3FF, 64'h0);
        #1;
        check("arst_b_rvalid", 64'(ib.rvalid_o), 64'h0);
        check("arst_b_data", ib.data_o, 64'h0);
        check("arst_a_user", 64'(ia.user_o), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        ia.req_i = 1'b0;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_a_data", ia.data_o, 64'h0);
            check("post_rst_b_data", ib.data_o, 64'h0);
        end
        op(0, 0, 64'h10, 8'h00, 10'h000, 64'h0);
        op(0, 0, 64'h20, 8'h00, 10'h000, 64'h0);
        op(0, 0, 64'h7F8, 8'h00, 10'h000, 64'h0);
        for (int w = 0; w < 8; w++)
            op(1, 0, 64'h1000 + 64'(w * 8), 8'h00, 10'h000, 64'h0);
        op(1, 0, 64'h17F8, 8'h00, 10'h000, 64'h0);
        idle(6);

        check("a_drained", 64'(qa.size()), 64'h0);
        check("b_drained", 64'(qb.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
